// File: rtl/mux_scan_pkg.sv
// Shared FSM state and mode encodings for the mux_scan_nch channel scanner.
package mux_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/dwell_counter.sv
// Dwell counter: counts 0..DWELL-1 while enabled, tc marks the last dwell cycle.
module dwell_counter #(
  parameter int DWELL = 4
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt;

  assign tc = (cnt == LAST);

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)     cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= tc ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/mux_scan_nch.sv
// N-channel registered mux with manual select and timed auto-scan.
// Optional channel skipping in scan is enabled by defining MUX_SCAN_MASK_EN.
module mux_scan_nch
  import mux_scan_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NCH   = 4,
  parameter int DWELL = 4,
  localparam int SELW = $clog2(NCH)
) (
  input  logic                  Clk_in,
  input  logic                  Reset_n_in,
  input  logic [NCH*WIDTH-1:0]  Data_in,
  input  logic [SELW-1:0]       Sel_in,
  input  logic                  Mode_in,
  input  logic                  Enable_in,
`ifdef MUX_SCAN_MASK_EN
  input  logic [NCH-1:0]        Mask_in,
`endif
  output logic [WIDTH-1:0]      Mux_out,
  output logic                  Valid_out,
  output logic [SELW-1:0]       Chan_out,
  output logic                  Wrap_out
);

  localparam int IW = $clog2(NCH * WIDTH);
  localparam logic [SELW:0] NCH_LIM = (SELW + 1)'(NCH);

  state_t           state;
  logic [NCH-1:0]   skip;
  logic             any_live, sel_ok, scanning, entering, tc;
  logic [SELW-1:0]  first_ch, adv_ch, scan_ch;
  logic [WIDTH-1:0] sel_data, scan_data;

`ifdef MUX_SCAN_MASK_EN
  assign skip = Mask_in;
`else
  assign skip = '0;
`endif

  // First non-skipped channel at or after 'start', wrapping past NCH-1.
  function automatic logic [SELW-1:0] next_live(input int start, input logic [NCH-1:0] skp);
    logic [SELW-1:0] r;
    logic [NCH-1:0]  t;
    int              c;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      c = (start + i) % NCH;
      t = skp >> c;
      if (!t[0]) r = SELW'(c);
    end
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] chan_slice(input logic [NCH*WIDTH-1:0] d,
                                                  input logic [SELW-1:0] idx);
    logic [IW-1:0] base;
    base = IW'(idx) * IW'(WIDTH);
    return d[base +: WIDTH];
  endfunction

  assign any_live  = ~&skip;
  assign sel_ok    = {1'b0, Sel_in} < NCH_LIM;
  assign scanning  = Enable_in && (Mode_in == MODE_SCAN);
  assign entering  = scanning && (state != SCAN);
  assign first_ch  = next_live(0, skip);
  assign adv_ch    = next_live(int'(Chan_out) + 1, skip);
  assign scan_ch   = entering ? first_ch : (tc ? adv_ch : Chan_out);
  assign sel_data  = chan_slice(Data_in, Sel_in);
  assign scan_data = chan_slice(Data_in, scan_ch);

  dwell_counter #(.DWELL(DWELL)) u_dwell (
    .gclk   (Clk_in),
    .grst_n (Reset_n_in),
    .clear  (!scanning || entering),
    .enable (scanning && any_live),
    .tc     (tc)
  );

  always_ff @(posedge Clk_in or negedge Reset_n_in) begin
    if (!Reset_n_in) begin
      state     <= IDLE;
      Mux_out   <= '0;
      Chan_out  <= '0;
      Valid_out <= 1'b0;
      Wrap_out  <= 1'b0;
    end else begin
      Wrap_out <= 1'b0;
      if (!Enable_in) begin
        state     <= IDLE;
        Valid_out <= 1'b0;
      end else if (Mode_in == MODE_MANUAL) begin
        state <= MANUAL;
        if (sel_ok) begin
          Mux_out   <= sel_data;
          Chan_out  <= Sel_in;
          Valid_out <= 1'b1;
        end else begin
          Mux_out   <= '0;
          Valid_out <= 1'b0;
        end
      end else begin
        state <= SCAN;
        if (any_live) begin
          Mux_out   <= scan_data;
          Chan_out  <= scan_ch;
          Valid_out <= 1'b1;
          // A wrap is any advance that moves to a lower index; re-entry never wraps.
          Wrap_out  <= !entering && tc && (adv_ch < Chan_out);
        end else begin
          Valid_out <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_nch.sv
// Directed bench for mux_scan_nch: default instance (4ch, dwell 4) and a 3ch dwell-1 instance.
module tb_mux_scan_nch;
  import mux_scan_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] data = 16'hD1BA;
  logic [1:0]  sel = '0;
  logic        mode = 1'b0, en = 1'b0;
  logic [3:0]  mask = '0;
  logic [3:0]  mux;
  logic        vld, wrap;
  logic [1:0]  chan;

  logic [11:0] data3 = 12'h987;
  logic [1:0]  sel3 = '0;
  logic        mode3 = 1'b0, en3 = 1'b0;
  logic [3:0]  mux3;
  logic        vld3, wrap3;
  logic [1:0]  chan3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux_scan_nch u_dut (
    .Clk_in(clk), .Reset_n_in(rst_n), .Data_in(data), .Sel_in(sel),
    .Mode_in(mode), .Enable_in(en),
`ifdef MUX_SCAN_MASK_EN
    .Mask_in(mask),
`endif
    .Mux_out(mux), .Valid_out(vld), .Chan_out(chan), .Wrap_out(wrap)
  );

  mux_scan_nch #(.WIDTH(4), .NCH(3), .DWELL(1)) u_dut3 (
    .Clk_in(clk), .Reset_n_in(rst_n), .Data_in(data3), .Sel_in(sel3),
    .Mode_in(mode3), .Enable_in(en3),
`ifdef MUX_SCAN_MASK_EN
    .Mask_in(3'b000),
`endif
    .Mux_out(mux3), .Valid_out(vld3), .Chan_out(chan3), .Wrap_out(wrap3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] nib(input logic [15:0] d, input int ch);
    return 4'(d >> (4 * ch));
  endfunction

  task automatic chk_out(input string tag, input logic [3:0] m, input logic [1:0] c,
                         input logic v, input logic w);
    chk({tag, ".mux"},  32'(mux),  32'(m));
    chk({tag, ".chan"}, 32'(chan), 32'(c));
    chk({tag, ".vld"},  32'(vld),  32'(v));
    chk({tag, ".wrap"}, 32'(wrap), 32'(w));
  endtask

  initial begin
    int ec;
    // Asynchronous reset and idle hold after release
    #2 rst_n = 1'b0;
    #1 chk_out("rst_async", 4'h0, 2'd0, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk_out("rst_idle", 4'h0, 2'd0, 1'b0, 1'b0);
    chk("rst_state", 32'(u_dut.state), 32'(IDLE));

    // Manual select, one-cycle latency, live tracking
    en = 1'b1; mode = 1'b0; sel = 2'd2;
    tick();
    chk_out("man_ch2", 4'h1, 2'd2, 1'b1, 1'b0);
    data = 16'hD7BA;
    tick();
    chk_out("man_live", 4'h7, 2'd2, 1'b1, 1'b0);
    sel = 2'd1;
    tick();
    chk_out("man_ch1", 4'hB, 2'd1, 1'b1, 1'b0);

    // Enable low: outputs held, valid dropped
    en = 1'b0;
    tick();
    chk_out("idle_hold", 4'hB, 2'd1, 1'b0, 1'b0);

    // Full scan from entry: dwell 4, wrap on 17th cycle
    en = 1'b1; mode = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      ec = ((k - 1) / 4) % 4;
      chk_out($sformatf("scan_k%0d", k), nib(data, ec), 2'(ec), 1'b1, k == 17);
    end

    // Mode toggle mid-dwell, then re-entry restarts at ch0 without wrap
    mode = 1'b0; sel = 2'd3;
    tick();
    chk_out("toggle_man", 4'hD, 2'd3, 1'b1, 1'b0);
    mode = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k <= 5)
        chk_out($sformatf("reenter_k%0d", k), nib(data, (k - 1) / 4), 2'((k - 1) / 4), 1'b1, 1'b0);
    end

    // Enable dropped exactly on the wrap edge
    en = 1'b0;
    tick();
    chk_out("wrap_drop", 4'hD, 2'd3, 1'b0, 1'b0);
    chk("wrap_drop_state", 32'(u_dut.state), 32'(IDLE));

    // Reset mid-dwell of channel 2
    en = 1'b1; mode = 1'b1;
    for (int k = 1; k <= 10; k++) tick();
    chk_out("pre_rst_ch2", 4'h7, 2'd2, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_out("rst_mid", 4'h0, 2'd0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1; en = 1'b0;
    tick();
    tick();
    chk_out("rst_mid_idle", 4'h0, 2'd0, 1'b0, 1'b0);
    chk("rst_mid_state", 32'(u_dut.state), 32'(IDLE));
    en = 1'b1; mode = 1'b0; sel = 2'd2;
    tick();
    chk_out("rst_mid_man", 4'h7, 2'd2, 1'b1, 1'b0);

`ifdef MUX_SCAN_MASK_EN
    // Skip channels 0 and 2: order 1,3,1,3 with wrap on each 3->1
    mask = 4'b0101; mode = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      ec = (((k - 1) / 4) % 2 == 0) ? 1 : 3;
      chk_out($sformatf("mask_k%0d", k), nib(data, ec), 2'(ec), 1'b1, (k == 9) || (k == 17));
    end
    mask = 4'b1111;
    tick();
    chk_out("mask_all", 4'hB, 2'd1, 1'b0, 1'b0);
    mask = 4'b0000;
`endif
    en = 1'b0;

    // NCH=3: out-of-range manual select, then dwell-1 scan
    en3 = 1'b1; mode3 = 1'b0; sel3 = 2'd1;
    tick();
    chk("n3_man.mux", 32'(mux3), 32'h8);
    chk("n3_man.chan", 32'(chan3), 32'd1);
    chk("n3_man.vld", 32'(vld3), 32'd1);
    sel3 = 2'd3;
    tick();
    chk("n3_oor.mux", 32'(mux3), 32'h0);
    chk("n3_oor.vld", 32'(vld3), 32'd0);
    chk("n3_oor.chan", 32'(chan3), 32'd1);
    mode3 = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      ec = (k - 1) % 3;
      chk($sformatf("n3_scan_k%0d.chan", k), 32'(chan3), 32'(ec));
      chk($sformatf("n3_scan_k%0d.mux", k), 32'(mux3), 32'(4'(data3 >> (4 * ec))));
      chk($sformatf("n3_scan_k%0d.wrap", k), 32'(wrap3), 32'((k == 4) || (k == 7)));
    end
    en3 = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
